// File: rtl/key_repeat_pkg.sv
// key_repeat_pkg: shared types and constants for the key-repeat tick generator.
package key_repeat_pkg;

   localparam int HALF_SEC_50MHZ = 25_000_000;
   // Wide enough to hold a half-second count at 50 MHz.
   localparam int DEFAULT_CNT_W  = $clog2(HALF_SEC_50MHZ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

endpackage

// File: rtl/key_repeat_gen_repeat_down_counter.sv
// repeat_down_counter: loadable down-counter that stops at zero instead of wrapping.
module repeat_down_counter
   import key_repeat_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] value_r;

   // Counter register: load wins over decrement, decrement saturates at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_r <= '0;
      end else if (load) begin
         value_r <= load_val;
      end else if (en && (value_r != '0)) begin
         value_r <= value_r - CNT_W'(1);
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;
   assign zero  = (value_r == '0);

endmodule

// File: rtl/key_repeat_gen.sv
// key_repeat_gen: emits one-hot move pulses on press, after a delay, then periodically.
// Optional macro KEY_REPEAT_SYNC_EN adds a 2-flop synchroniser per key channel.
module key_repeat_gen
   import key_repeat_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [CH-1:0]         key_in,
   input  logic [CNT_W-1:0]      delay_cycles,
   input  logic [CNT_W-1:0]      repeat_cycles,
   output logic [CH-1:0]         pulse,
   output logic                  busy,
   output logic [$clog2(CH)-1:0] active_ch
);

   localparam int CH_W = $clog2(CH);

   // A programmed count of 0 behaves like 1; the counter holds count-1.
   function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] cycles);
      clamp_load = (cycles == '0) ? '0 : (cycles - CNT_W'(1));
   endfunction

   function automatic logic [CH_W-1:0] lowest_set(input logic [CH-1:0] keys);
      lowest_set = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (keys[i]) begin
            lowest_set = CH_W'(i);
         end
      end
   endfunction

   logic [CH-1:0]    key_s;
   state_e           state_r;
   state_e           state_nxt_s;
   logic [CH_W-1:0]  new_ch_s;
   logic [CH_W-1:0]  sel_ch_s;
   logic             key_held_s;
   logic             fire_s;
   logic             load_s;
   logic [CNT_W-1:0] load_val_s;
   logic             cnt_en_s;
   logic [CNT_W-1:0] cnt_value_s;
   logic             cnt_zero_s;
   logic [CH-1:0]    pulse_r;
   logic             busy_r;
   logic [CH_W-1:0]  active_ch_r;

`ifdef KEY_REPEAT_SYNC_EN
   logic [CH-1:0] sync1_r;
   logic [CH-1:0] sync2_r;

   // Two-flop synchroniser for asynchronous key levels.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
      end
   end

   assign key_s = sync2_r;
`else
   assign key_s = key_in;
`endif

   assign new_ch_s   = lowest_set(key_s);
   assign key_held_s = key_s[active_ch_r];

   repeat_down_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (load_s),
      .load_val (load_val_s),
      .en       (cnt_en_s),
      .value    (cnt_value_s),
      .zero     (cnt_zero_s)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: release of the tracked key always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable && (|key_s)) begin
               state_nxt_s = DELAY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DELAY: begin
            if (!key_held_s) begin
               state_nxt_s = IDLE;
            end else if (enable && cnt_zero_s) begin
               state_nxt_s = REPEAT;
            end else begin
               state_nxt_s = DELAY;
            end
         end
         REPEAT: begin
            if (!key_held_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = REPEAT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output/control decode: when to fire, what to load, when to count.
   always_comb begin
      fire_s     = 1'b0;
      load_s     = 1'b0;
      load_val_s = '0;
      cnt_en_s   = 1'b0;
      sel_ch_s   = active_ch_r;
      case (state_r)
         IDLE: begin
            sel_ch_s = new_ch_s;
            if (enable && (|key_s)) begin
               fire_s     = 1'b1;
               load_s     = 1'b1;
               load_val_s = clamp_load(delay_cycles);
            end else begin
               fire_s = 1'b0;
            end
         end
         DELAY, REPEAT: begin
            if (!key_held_s) begin
               fire_s = 1'b0;
            end else if (enable && cnt_zero_s) begin
               fire_s     = 1'b1;
               load_s     = 1'b1;
               load_val_s = clamp_load(repeat_cycles);
            end else if (enable) begin
               cnt_en_s = (cnt_value_s != '0);
            end else begin
               cnt_en_s = 1'b0;
            end
         end
         default: begin
            fire_s = 1'b0;
         end
      endcase
   end

   // Registered outputs, all cleared immediately by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pulse_r     <= '0;
         busy_r      <= 1'b0;
         active_ch_r <= '0;
      end else begin
         pulse_r     <= fire_s ? (CH'(1) << sel_ch_s) : '0;
         busy_r      <= (state_nxt_s != IDLE);
         active_ch_r <= (state_nxt_s != IDLE) ? sel_ch_s : '0;
      end
   end

   assign pulse     = pulse_r;
   assign busy      = busy_r;
   assign active_ch = active_ch_r;

endmodule

// File: tb/tb_key_repeat_gen.sv
// Self-checking bench for key_repeat_gen: vector table, directed corner sequences,
// and randomized stimulus against a behavioural model.
module tb_key_repeat_gen;

`ifdef KEY_REPEAT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clock;
   logic        reset;
   logic        enable;
   logic [3:0]  key_in;
   logic [24:0] delay_cycles;
   logic [24:0] repeat_cycles;
   logic [3:0]  pulse;
   logic        busy;
   logic [1:0]  active_ch;

   int n_pass;
   int n_total;

   key_repeat_gen #(.CH(4), .CNT_W(25)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .key_in        (key_in),
      .delay_cycles  (delay_cycles),
      .repeat_cycles (repeat_cycles),
      .pulse         (pulse),
      .busy          (busy),
      .active_ch     (active_ch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick(input logic [3:0] k, input logic e);
      key_in = k;
      enable = e;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      key_in = 4'b0000;
      enable = 1'b1;
      reset  = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Behavioural model: remaining enabled edges until the next pulse.
   int         m_busy;
   int         m_ch;
   int         m_rem;
   logic [3:0] m_pulse;
   logic [3:0] kd1;
   logic [3:0] kd2;

   task automatic model_reset();
      m_busy = 0; m_ch = 0; m_rem = 0; m_pulse = 4'b0000;
      kd1 = 4'b0000; kd2 = 4'b0000;
   endtask

   task automatic model_step(input logic [3:0] k_raw, input logic e, input int d, input int r);
      logic [3:0] k;
      if (LAT == 2) begin
         k = kd2; kd2 = kd1; kd1 = k_raw;
      end else begin
         k = k_raw;
      end
      m_pulse = 4'b0000;
      if (m_busy == 0) begin
         if (e && (k != 4'b0000)) begin
            for (int i = 3; i >= 0; i--) if (k[i]) m_ch = i;
            m_busy = 1;
            m_pulse[m_ch] = 1'b1;
            m_rem = (d < 1) ? 1 : d;
         end
      end else if (!k[m_ch]) begin
         m_busy = 0;
         m_ch = 0;
      end else if (e) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            m_pulse[m_ch] = 1'b1;
            m_rem = (r < 1) ? 1 : r;
         end
      end
   endtask

   typedef struct {
      logic [3:0] key;
      logic [3:0] exp_pulse;
      logic       exp_busy;
      logic [1:0] exp_ch;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   initial begin
      int d_r;
      int r_r;
      logic [3:0] k_r;
      logic       e_r;
      n_pass = 0;
      n_total = 0;
      delay_cycles  = 25'd5;
      repeat_cycles = 25'd3;
      key_in = 4'b0000;
      enable = 1'b1;
      reset  = 1'b1;
      #2;
      chk("reset_pulse", 32'(pulse), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ch", 32'(active_ch), 32'd0);

      // Table: D=5, R=3, enable held high; expected outputs after each edge.
      tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
      tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[3]  = '{4'b1010, 4'b0010, 1'b1, 2'd1};
      tbl[4]  = '{4'b1010, 4'b0000, 1'b1, 2'd1};
      tbl[5]  = '{4'b1000, 4'b0000, 1'b0, 2'd0};
      tbl[6]  = '{4'b1000, 4'b1000, 1'b1, 2'd3};
      tbl[7]  = '{4'b1000, 4'b0000, 1'b1, 2'd3};
      tbl[8]  = '{4'b1111, 4'b0000, 1'b1, 2'd3};
      tbl[9]  = '{4'b0111, 4'b0000, 1'b0, 2'd0};
      tbl[10] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
      for (int i = 11; i <= 14; i++) tbl[i] = '{4'b0001, 4'b0000, 1'b1, 2'd0};
      tbl[15] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
      tbl[16] = '{4'b0001, 4'b0000, 1'b1, 2'd0};
      tbl[17] = '{4'b0001, 4'b0000, 1'b1, 2'd0};
      tbl[18] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
      tbl[19] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
      tbl[20] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

      do_reset();
      for (int i = 0; i < NV + LAT; i++) begin
         tick((i < NV) ? tbl[i].key : 4'b0000, 1'b1);
         if (i >= LAT) begin
            chk($sformatf("tbl%0d_pulse", i - LAT), 32'(pulse), 32'(tbl[i - LAT].exp_pulse));
            chk($sformatf("tbl%0d_busy", i - LAT), 32'(busy), 32'(tbl[i - LAT].exp_busy));
            chk($sformatf("tbl%0d_ch", i - LAT), 32'(active_ch), 32'(tbl[i - LAT].exp_ch));
         end
      end

      // Hold: ch0 held edges 10..25, D=5, R=3.
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         int t;
         t = e - LAT;
         tick((e >= 10 && e <= 25) ? 4'b0001 : 4'b0000, 1'b1);
         chk($sformatf("hold_e%0d", e), 32'(pulse),
             (t == 10 || t == 15 || t == 18 || t == 21 || t == 24) ? 32'd1 : 32'd0);
      end

      // Enable gating: D=4, R=3, ch3 held 10..22, enable low for four edges.
      delay_cycles = 25'd4;
      do_reset();
      for (int e = 1; e <= 26; e++) begin
         int t;
         t = e - LAT;
         tick((e >= 10 && e <= 22) ? 4'b1000 : 4'b0000, !(t >= 12 && t <= 15));
         chk($sformatf("gate_e%0d", e), 32'(pulse),
             (t == 10 || t == 18 || t == 21) ? 32'h8 : 32'd0);
      end

      // Zero delay and unit period: a pulse on every held edge.
      delay_cycles  = 25'd0;
      repeat_cycles = 25'd1;
      do_reset();
      for (int e = 1; e <= 16; e++) begin
         int t;
         t = e - LAT;
         tick((e >= 5 && e <= 12) ? 4'b0100 : 4'b0000, 1'b1);
         chk($sformatf("d0_e%0d", e), 32'(pulse), (t >= 5 && t <= 12) ? 32'h4 : 32'd0);
      end

      // Async reset in REPEAT, between edges, with the key still held.
      delay_cycles  = 25'd2;
      repeat_cycles = 25'd2;
      do_reset();
      for (int e = 1; e <= 7 + LAT; e++) tick(4'b0010, 1'b1);
      chk("pre_reset_pulse", 32'(pulse), 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_pulse", 32'(pulse), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ch", 32'(active_ch), 32'd0);
      reset = 1'b0;
      for (int e = 1; e <= LAT + 1; e++) begin
         tick(4'b0010, 1'b1);
         chk($sformatf("repress_e%0d", e), 32'(pulse), (e == LAT + 1) ? 32'h2 : 32'd0);
      end
      chk("repress_ch", 32'(active_ch), 32'd1);

      // Randomized run against the behavioural model.
      d_r = 3; r_r = 2; k_r = 4'b0000; e_r = 1'b1;
      delay_cycles  = 25'(d_r);
      repeat_cycles = 25'(r_r);
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 63) == 0) d_r = $urandom_range(0, 6);
         if ($urandom_range(0, 63) == 0) r_r = $urandom_range(0, 6);
         if ($urandom_range(0, 7) == 0) k_r = 4'($urandom_range(0, 15));
         e_r = ($urandom_range(0, 7) != 0);
         delay_cycles  = 25'(d_r);
         repeat_cycles = 25'(r_r);
         tick(k_r, e_r);
         model_step(k_r, e_r, d_r, r_r);
         chk($sformatf("rnd%0d_pulse", c), 32'(pulse), 32'(m_pulse));
         chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_busy));
         chk($sformatf("rnd%0d_ch", c), 32'(active_ch), 32'(m_ch));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
